// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and default constants for audio ROM playback
package audio_pkg;

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_STRM,
        OWN_CPU
    } owner_t;

    localparam int SAMPLE_W        = 16;
    localparam int CLK_HZ          = 50_000_000;
    localparam int SAMPLE_RATE_HZ  = 16_000;
    localparam int DEF_CLK_DIV     = CLK_HZ / SAMPLE_RATE_HZ;
    localparam int DEF_NUM_SAMPLES = 32000;

    // Counter width for a range of n values, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - sample-period divider producing a 1-cycle tick
module sample_tick_gen #(
    parameter int CLK_DIV = audio_pkg::DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    import audio_pkg::*;

    localparam int DIV_W = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0] RELOAD = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // Count down while enabled; reload on wrap, on clear and on reset
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            div_cnt <= RELOAD;
        end else if (en) begin
            if (div_cnt == '0) begin
                div_cnt <= RELOAD;
            end else begin
                div_cnt <= div_cnt - DIV_W'(1);
            end
        end
    end

    // The tick is the cycle in which the counter sits at zero
    assign tick = en && !clr && (div_cnt == '0);

endmodule

// File: rtl/audio_rom_ctrl.sv
// rtl/audio_rom_ctrl.sv - audio sample ROM playback sequencer with shared CPU read port
module audio_rom_ctrl #(
    parameter int NUM_SAMPLES = audio_pkg::DEF_NUM_SAMPLES,
    parameter int CLK_DIV     = audio_pkg::DEF_CLK_DIV,
    parameter int SAMPLE_W    = audio_pkg::SAMPLE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic                loop_en,
    output logic                busy,
    output logic                done,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    input  logic                cpu_req,
    input  logic [31:0]         cpu_addr,
    output logic [SAMPLE_W-1:0] cpu_rdata,
    output logic                cpu_rvalid,
    output logic [31:0]         rom_addr,
    input  logic [SAMPLE_W-1:0] rom_rd
);
    import audio_pkg::*;

    localparam int IDX_W = cnt_width(NUM_SAMPLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);

    state_t           state;
    owner_t           own_q;      // owner of the address presented to the ROM this cycle
    owner_t           own_d;      // owner of the data the ROM returns this cycle
    logic             fetch_pend;
    logic [IDX_W-1:0] idx;

    logic             tick;
    logic             tick_en;
    logic             tick_clr;
    logic             go;
    logic             play_ok;
    logic             strm_busy;
    logic             cpu_busy;
    logic             strm_req;
    logic             strm_grant;
    logic             cpu_grant;
    logic             strm_ret;
    logic [IDX_W-1:0] idx_sel;

    assign tick_en  = (state == PLAY);
    assign tick_clr = (state != PLAY) || stop || done;

    sample_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_en),
        .clr   (tick_clr),
        .tick  (tick)
    );

    // A start pulse requests its first fetch in the same cycle; later fetches
    // come from the divider tick, or from a tick that had to wait
    assign go         = (state == IDLE) && start && !stop;
    assign play_ok    = (state == PLAY) && !stop && !done;
    assign strm_busy  = (own_q == OWN_STRM) || (own_d == OWN_STRM);
    assign cpu_busy   = (own_q == OWN_CPU) || (own_d == OWN_CPU) || cpu_rvalid;
    assign strm_req   = go || (play_ok && (fetch_pend || tick));
    assign strm_grant = strm_req && !strm_busy;
    assign cpu_grant  = !strm_grant && cpu_req && !cpu_busy;
    assign strm_ret   = (own_d == OWN_STRM) && (state == PLAY) && !stop;
    assign idx_sel    = go ? '0 : idx;

    assign busy = (state == PLAY);

    // Playback FSM, ROM port arbitration and return-data steering
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            own_q        <= OWN_NONE;
            own_d        <= OWN_NONE;
            fetch_pend   <= 1'b0;
            idx          <= '0;
            rom_addr     <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            done         <= 1'b0;
            cpu_rdata    <= '0;
            cpu_rvalid   <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            done         <= 1'b0;
            cpu_rvalid   <= 1'b0;

            if (strm_grant) begin
                rom_addr <= {{(30 - IDX_W){1'b0}}, idx_sel, 2'b00};
                own_q    <= OWN_STRM;
            end else if (cpu_grant) begin
                rom_addr <= cpu_addr;
                own_q    <= OWN_CPU;
            end else begin
                own_q    <= OWN_NONE;
            end

            // A stop drops any stream read already on its way back
            own_d <= (stop && own_q == OWN_STRM) ? OWN_NONE : own_q;

            if (strm_grant || !(go || play_ok)) begin
                fetch_pend <= 1'b0;
            end else if (strm_req) begin
                fetch_pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (go) begin
                        state <= PLAY;
                        idx   <= '0;
                    end
                end
                PLAY: begin
                    if (stop || done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (strm_ret) begin
                sample_out   <= rom_rd;
                sample_valid <= 1'b1;
                if (idx == LAST_IDX) begin
                    idx <= '0;
                    if (!loop_en) begin
                        done <= 1'b1;
                    end
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end

            if (own_d == OWN_CPU) begin
                cpu_rdata  <= rom_rd;
                cpu_rvalid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_audio_rom_ctrl.sv
// tb/tb_audio_rom_ctrl.sv - scoreboard bench for audio_rom_ctrl with a ramp ROM
module tb_audio_rom_ctrl;

    localparam int NS  = 8;
    localparam int DIV = 4;
    localparam int SW  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop_en = 1'b0;
    logic          busy;
    logic          done;
    logic [SW-1:0] sample_out;
    logic          sample_valid;
    logic          cpu_req = 1'b0;
    logic [31:0]   cpu_addr = '0;
    logic [SW-1:0] cpu_rdata;
    logic          cpu_rvalid;
    logic [31:0]   rom_addr;
    logic [SW-1:0] rom_rd = '0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic [15:0] val;
        bit          dn;
    } sexp_t;

    typedef struct {
        int          cyc;
        logic [15:0] val;
    } cexp_t;

    sexp_t sq[$];
    cexp_t cq[$];

    audio_rom_ctrl #(
        .NUM_SAMPLES (NS),
        .CLK_DIV     (DIV),
        .SAMPLE_W    (SW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .loop_en      (loop_en),
        .busy         (busy),
        .done         (done),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .cpu_req      (cpu_req),
        .cpu_addr     (cpu_addr),
        .cpu_rdata    (cpu_rdata),
        .cpu_rvalid   (cpu_rvalid),
        .rom_addr     (rom_addr),
        .rom_rd       (rom_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Ramp ROM, word k holds k, one registered cycle of read latency
    logic [29:0] rom_word;
    assign rom_word = rom_addr[31:2];
    always @(posedge clk) rom_rd <= rom_word[SW-1:0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop expectations whenever the DUT strobes an output
    always @(negedge clk) begin
        sexp_t se;
        cexp_t ce;
        if (sample_valid) begin
            if (sq.size() == 0) begin
                chk("unexpected_sample_valid", {16'h0, sample_out}, 32'hFFFF_FFFF);
            end else begin
                se = sq.pop_front();
                chk("sample_cycle", 32'(cyc), 32'(se.cyc));
                chk("sample_value", {16'h0, sample_out}, {16'h0, se.val});
                chk("done_with_sample", {31'h0, done}, {31'h0, se.dn});
            end
        end else if (done) begin
            chk("done_without_sample", {31'h0, done}, 32'h0);
        end
        if (sq.size() > 0 && sq[0].cyc < cyc) begin
            chk("sample_missed", 32'(cyc), 32'(sq[0].cyc));
            void'(sq.pop_front());
        end
        if (cpu_rvalid) begin
            if (cq.size() == 0) begin
                chk("unexpected_cpu_rvalid", {16'h0, cpu_rdata}, 32'hFFFF_FFFF);
            end else begin
                ce = cq.pop_front();
                chk("cpu_cycle", 32'(cyc), 32'(ce.cyc));
                chk("cpu_rdata", {16'h0, cpu_rdata}, {16'h0, ce.val});
            end
        end
        if (cq.size() > 0 && cq[0].cyc < cyc) begin
            chk("cpu_missed", 32'(cyc), 32'(cq[0].cyc));
            void'(cq.pop_front());
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_start(output int t);
        t = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Start sampled at edge t+1 fetches at once; sample k shows at t+3+4k
    task automatic push_play(input int t, input int cnt, input bit lp);
        sexp_t e;
        for (int k = 0; k < cnt; k++) begin
            e.cyc = t + 3 + DIV * k;
            e.val = 16'(k % NS);
            e.dn  = !lp && (k == NS - 1);
            sq.push_back(e);
        end
    endtask

    task automatic push_cpu(input int c, input logic [15:0] v);
        cexp_t e;
        e.cyc = c;
        e.val = v;
        cq.push_back(e);
    endtask

    task automatic cpu_read(input logic [31:0] a);
        int n;
        cpu_addr = a;
        cpu_req  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_rvalid && n < 20);
        chk("cpu_rvalid_seen", {31'h0, cpu_rvalid}, 32'h1);
        cpu_req = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
        chk({tag, "_done"}, {31'h0, done}, 32'h0);
        chk({tag, "_sample_valid"}, {31'h0, sample_valid}, 32'h0);
        chk({tag, "_sample_out"}, {16'h0, sample_out}, 32'h0);
        chk({tag, "_cpu_rvalid"}, {31'h0, cpu_rvalid}, 32'h0);
        chk({tag, "_cpu_rdata"}, {16'h0, cpu_rdata}, 32'h0);
        chk({tag, "_rom_addr"}, rom_addr, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single pass, values 0..7, done with 7, busy drops one cycle later
        loop_en = 1'b0;
        pulse_start(t);
        push_play(t, NS, 1'b0);
        chk("busy_after_start", {31'h0, busy}, 32'h1);
        wait_until(t + 3 + DIV * (NS - 1));
        chk("busy_at_done", {31'h0, busy}, 32'h1);
        @(negedge clk);
        chk("busy_after_done", {31'h0, busy}, 32'h0);
        repeat (6) @(negedge clk);

        // 2: looping wraps 7 -> 0 without done, then stop
        loop_en = 1'b1;
        pulse_start(t);
        push_play(t, 10, 1'b1);
        wait_until(t + 40);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("busy_after_stop", {31'h0, busy}, 32'h0);
        repeat (12) @(negedge clk);
        loop_en = 1'b0;

        // 3: CPU read while idle
        push_cpu(cyc + 3, 16'd5);
        cpu_read(32'h14);
        repeat (3) @(negedge clk);

        // 4: CPU request colliding with a stream tick
        pulse_start(t);
        push_play(t, NS, 1'b0);
        wait_until(t + 4);
        push_cpu(t + 8, 16'd7);
        cpu_read(32'h1C);
        wait_until(t + 3 + DIV * NS);
        repeat (3) @(negedge clk);

        // 5: stop right after a stream grant, CPU read issued alongside
        pulse_start(t);
        push_play(t, 1, 1'b0);
        fork
            begin
                wait_until(t + 4);
                push_cpu(t + 8, 16'd6);
                cpu_read(32'h18);
            end
            begin
                wait_until(t + 5);
                stop = 1'b1;
                @(negedge clk);
                stop = 1'b0;
                chk("busy_after_midfetch_stop", {31'h0, busy}, 32'h0);
            end
        join
        repeat (10) @(negedge clk);

        // 6: reset mid-playback clears everything, restart begins at 0
        pulse_start(t);
        push_play(t, 2, 1'b0);
        wait_until(t + 9);
        rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("midreset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        pulse_start(t);
        push_play(t, NS, 1'b0);
        wait_until(t + 3 + DIV * NS);
        repeat (6) @(negedge clk);

        chk("stream_queue_drained", 32'(sq.size()), 32'h0);
        chk("cpu_queue_drained", 32'(cq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
